apple_spawn_ctrl: RTL and testbench

- Sequences apple placement after the snake eats.
- Latches a random seed, then drives candidate grid coordinates in raster order to the external occupancy checker (inquiry instance, combinational, same-cycle answer).
- Skips a seed-derived number of free cells and commits the next free cell as the new apple.
- Sits between the game FSM (cstate, eat event) and the apple register and display.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/raster_cursor.sv | 45 ++++
 rtl/apple_spawn_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_apple_spawn_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game blocks: grid geometry,
// game-state encodings, the apple spawn controller state type and a
// saturating counter helper.
package snake_pkg;

    localparam int GRID_W  = 64;
    localparam int GRID_H  = 48;
    localparam int COORD_W = 6;
    localparam int SEED_W  = 12;
    localparam int SKIP_W  = 8;

    // Game FSM state as seen on cstate; only PLAY is meaningful here.
    localparam logic [1:0] CSTATE_PLAY = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        SCAN = 2'b10
    } spawn_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/raster_cursor.sv
// Raster-order grid cursor: clear to (0,0), or step x then y with wrap
// back to (0,0) after the last cell. Coordinates never leave the grid.
module raster_cursor #(
    parameter int GRID_W  = snake_pkg::GRID_W,
    parameter int GRID_H  = snake_pkg::GRID_H,
    parameter int COORD_W = snake_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);
    import snake_pkg::*;

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;

    // Cursor register: clear has priority over advance; end of row steps y.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x_r <= {COORD_W{1'b0}};
            y_r <= {COORD_W{1'b0}};
        end else if (adv) begin
            if (x_r == X_MAX) begin
                x_r <= {COORD_W{1'b0}};
                if (y_r == Y_MAX) begin
                    y_r <= {COORD_W{1'b0}};
                end else begin
                    y_r <= y_r + COORD_W'(1);
                end
            end else begin
                x_r <= x_r + COORD_W'(1);
            end
        end
    end

    assign x = x_r;
    assign y = y_r;

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple spawn controller. After an eat event it latches a random skip
// count, walks the grid in raster order asking the external occupancy
// checker about each cell, skips that many free cells and commits the next
// free one as the apple. A full board yields a spawn_fail pulse.
// Optional statistics outputs are enabled with APPLE_SPAWN_STATS_EN.
module apple_spawn_ctrl #(
    parameter int GRID_W  = snake_pkg::GRID_W,
    parameter int GRID_H  = snake_pkg::GRID_H,
    parameter int COORD_W = snake_pkg::COORD_W,
    parameter int SEED_W  = snake_pkg::SEED_W,
    parameter int SKIP_W  = snake_pkg::SKIP_W
) (
    input  logic               OSC_50,
    input  logic               rst,
    input  logic [1:0]         cstate,
    input  logic               eat,
    input  logic [SEED_W-1:0]  randomseed,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    input  logic               cand_occupied,
    output logic [COORD_W-1:0] apple_x,
    output logic [COORD_W-1:0] apple_y,
    output logic               apple_valid,
    output logic               busy,
`ifdef APPLE_SPAWN_STATS_EN
    output logic [15:0]        spawn_cnt,
    output logic [15:0]        last_scan_len,
`endif
    output logic               spawn_done,
    output logic               spawn_fail
);
    import snake_pkg::*;

    // since_free must reach GRID_W*GRID_H-1 without wrapping.
    localparam int CNT_W = $clog2(GRID_W * GRID_H);
    localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(GRID_W * GRID_H - 1);

    spawn_state_t       state_r, next_state_s;
    logic [SKIP_W-1:0]  skip_r, skip_nxt_s;
    logic [CNT_W-1:0]   since_free_r, since_free_nxt_s;
    logic [COORD_W-1:0] apple_x_r, apple_x_nxt_s;
    logic [COORD_W-1:0] apple_y_r, apple_y_nxt_s;
    logic               apple_valid_r, apple_valid_nxt_s;
    logic               pending_r, pending_nxt_s;
    logic               done_r, done_nxt_s;
    logic               fail_r, fail_nxt_s;
    logic               busy_r;
    logic               cur_clr_s, cur_adv_s;
    logic               play_s;
    logic [COORD_W-1:0] cur_x_s, cur_y_s;
    logic               unused_seed_bits_s;

    assign play_s = (cstate == CSTATE_PLAY);
    // Only the low SKIP_W seed bits are meaningful here.
    assign unused_seed_bits_s = ^randomseed[SEED_W-1:SKIP_W];

    raster_cursor #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .COORD_W (COORD_W)
    ) u_cursor (
        .clk (OSC_50),
        .rst (rst),
        .clr (cur_clr_s),
        .adv (cur_adv_s),
        .x   (cur_x_s),
        .y   (cur_y_s)
    );

    // Next-state, cursor control and datapath updates for the spawn FSM.
    always_comb begin
        next_state_s      = state_r;
        skip_nxt_s        = skip_r;
        since_free_nxt_s  = since_free_r;
        apple_x_nxt_s     = apple_x_r;
        apple_y_nxt_s     = apple_y_r;
        apple_valid_nxt_s = apple_valid_r;
        pending_nxt_s     = pending_r;
        done_nxt_s        = 1'b0;
        fail_nxt_s        = 1'b0;
        cur_clr_s         = 1'b0;
        cur_adv_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if ((eat || pending_r) && play_s) begin
                    next_state_s  = LOAD;
                    pending_nxt_s = 1'b0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (!play_s) begin
                    // Game left PLAY: drop the request silently.
                    next_state_s  = IDLE;
                    pending_nxt_s = 1'b0;
                end else begin
                    pending_nxt_s    = pending_r | eat;
                    skip_nxt_s       = randomseed[SKIP_W-1:0];
                    since_free_nxt_s = {CNT_W{1'b0}};
                    cur_clr_s        = 1'b1;
                    next_state_s     = SCAN;
                end
            end
            SCAN: begin
                if (!play_s) begin
                    next_state_s  = IDLE;
                    pending_nxt_s = 1'b0;
                end else begin
                    pending_nxt_s = pending_r | eat;
                    if (!cand_occupied) begin
                        if (skip_r == {SKIP_W{1'b0}}) begin
                            apple_x_nxt_s     = cur_x_s;
                            apple_y_nxt_s     = cur_y_s;
                            apple_valid_nxt_s = 1'b1;
                            done_nxt_s        = 1'b1;
                            next_state_s      = IDLE;
                        end else begin
                            skip_nxt_s       = skip_r - SKIP_W'(1);
                            since_free_nxt_s = {CNT_W{1'b0}};
                            cur_adv_s        = 1'b1;
                        end
                    end else begin
                        if (since_free_r == LAST_CELL) begin
                            // A whole sweep without a free cell: board is full.
                            apple_valid_nxt_s = 1'b0;
                            fail_nxt_s        = 1'b1;
                            next_state_s      = IDLE;
                        end else begin
                            since_free_nxt_s = since_free_r + CNT_W'(1);
                            cur_adv_s        = 1'b1;
                        end
                    end
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counters, apple register and registered status outputs.
    always_ff @(posedge OSC_50) begin
        if (rst) begin
            state_r       <= IDLE;
            skip_r        <= {SKIP_W{1'b0}};
            since_free_r  <= {CNT_W{1'b0}};
            apple_x_r     <= COORD_W'(1);
            apple_y_r     <= COORD_W'(1);
            apple_valid_r <= 1'b1;
            pending_r     <= 1'b0;
            done_r        <= 1'b0;
            fail_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            skip_r        <= skip_nxt_s;
            since_free_r  <= since_free_nxt_s;
            apple_x_r     <= apple_x_nxt_s;
            apple_y_r     <= apple_y_nxt_s;
            apple_valid_r <= apple_valid_nxt_s;
            pending_r     <= pending_nxt_s;
            done_r        <= done_nxt_s;
            fail_r        <= fail_nxt_s;
            busy_r        <= (next_state_s != IDLE);
        end
    end

`ifdef APPLE_SPAWN_STATS_EN
    logic [15:0] spawn_cnt_r;
    logic [15:0] scan_cnt_r;
    logic [15:0] last_scan_len_r;

    // Spawn counter and per-scan cycle measurement, both saturating.
    always_ff @(posedge OSC_50) begin
        if (rst) begin
            spawn_cnt_r     <= 16'd0;
            scan_cnt_r      <= 16'd0;
            last_scan_len_r <= 16'd0;
        end else begin
            if (done_nxt_s) begin
                spawn_cnt_r <= sat_inc16(spawn_cnt_r);
            end
            if (state_r == LOAD) begin
                scan_cnt_r <= 16'd0;
            end else if (state_r == SCAN) begin
                scan_cnt_r <= sat_inc16(scan_cnt_r);
            end
            if (done_nxt_s || fail_nxt_s) begin
                last_scan_len_r <= sat_inc16(scan_cnt_r);
            end
        end
    end

    assign spawn_cnt     = spawn_cnt_r;
    assign last_scan_len = last_scan_len_r;
`endif

    assign cand_x      = cur_x_s;
    assign cand_y      = cur_y_s;
    assign apple_x     = apple_x_r;
    assign apple_y     = apple_y_r;
    assign apple_valid = apple_valid_r;
    assign busy        = busy_r;
    assign spawn_done  = done_r;
    assign spawn_fail  = fail_r;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Directed bench for apple_spawn_ctrl with a behavioural occupancy checker.
module tb_apple_spawn_ctrl;

    logic        OSC_50 = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cstate = 2'b01;
    logic        eat = 1'b0;
    logic [11:0] randomseed = 12'h000;
    logic [5:0]  cand_x, cand_y, apple_x, apple_y;
    logic        cand_occupied, apple_valid, busy;
    logic        spawn_done, spawn_fail;
`ifdef APPLE_SPAWN_STATS_EN
    logic [15:0] spawn_cnt, last_scan_len;
`endif

    // 0 empty, 1 row 0 full, 2 all full, 3 only (10,20) free
    int occ_mode = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int n_cyc, busy_cyc;
    logic saw_done, saw_fail;

    apple_spawn_ctrl dut (
        .OSC_50        (OSC_50),
        .rst           (rst),
        .cstate        (cstate),
        .eat           (eat),
        .randomseed    (randomseed),
        .cand_x        (cand_x),
        .cand_y        (cand_y),
        .cand_occupied (cand_occupied),
        .apple_x       (apple_x),
        .apple_y       (apple_y),
        .apple_valid   (apple_valid),
        .busy          (busy),
`ifdef APPLE_SPAWN_STATS_EN
        .spawn_cnt     (spawn_cnt),
        .last_scan_len (last_scan_len),
`endif
        .spawn_done    (spawn_done),
        .spawn_fail    (spawn_fail)
    );

    always #5 OSC_50 = ~OSC_50;

    // Combinational occupancy model
    always_comb begin
        case (occ_mode)
            1: cand_occupied = (cand_y == 6'd0);
            2: cand_occupied = 1'b1;
            3: cand_occupied = !((cand_x == 6'd10) && (cand_y == 6'd20));
            default: cand_occupied = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic pulse_eat();
        @(negedge OSC_50);
        eat = 1'b1;
        @(negedge OSC_50);
        eat = 1'b0;
    endtask

    // Wait (bounded) for a done/fail pulse; n = cycles after the eat edge.
    task automatic wait_evt(input int limit, output int n, output int bc,
                            output logic d, output logic f);
        n = 0;
        bc = 0;
        d = 1'b0;
        f = 1'b0;
        if (busy) bc++;
        while (n < limit) begin
            @(negedge OSC_50);
            n++;
            if (spawn_done || spawn_fail) begin
                d = spawn_done;
                f = spawn_fail;
                break;
            end
            if (busy) bc++;
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge OSC_50);
        chk("rst_apple_x", 32'(apple_x), 32'd1);
        chk("rst_apple_y", 32'(apple_y), 32'd1);
        chk("rst_valid", 32'(apple_valid), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_fail", 32'({spawn_done, spawn_fail}), 32'd0);
        chk("rst_cand", 32'({cand_x, cand_y}), 32'd0);
        rst = 1'b0;

        // Empty board, seed 0: commit at edge k+2, busy 2 cycles
        randomseed = 12'h000;
        pulse_eat();
        wait_evt(20, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("s0_done", 32'(saw_done), 32'd1);
        chk("s0_lat", 32'(n_cyc), 32'd2);
        chk("s0_busy_cyc", 32'(busy_cyc), 32'd2);
        chk("s0_busy_low", 32'(busy), 32'd0);
        chk("s0_apple", 32'({apple_x, apple_y}), 32'({6'd0, 6'd0}));
        @(negedge OSC_50);
        chk("s0_done_1cyc", 32'(spawn_done), 32'd0);

        // Skip 5 on empty board
        randomseed = 12'h105;
        pulse_eat();
        wait_evt(50, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("s5_lat", 32'(n_cyc), 32'd7);
        chk("s5_apple", 32'({apple_x, apple_y}), 32'({6'd5, 6'd0}));

        // Skip 255 on empty board
        randomseed = 12'h0FF;
        pulse_eat();
        wait_evt(400, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("s255_done", 32'(saw_done), 32'd1);
        chk("s255_apple", 32'({apple_x, apple_y}), 32'({6'd63, 6'd3}));

        // Row 0 occupied
        occ_mode = 1;
        randomseed = 12'h000;
        pulse_eat();
        wait_evt(200, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("row0_lat", 32'(n_cyc), 32'd66);
        chk("row0_apple", 32'({apple_x, apple_y}), 32'({6'd0, 6'd1}));

        // Full board
        occ_mode = 2;
        pulse_eat();
        wait_evt(4000, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("full_fail", 32'({saw_done, saw_fail}), 32'b01);
        chk("full_lat", 32'(n_cyc), 32'd3073);
        chk("full_valid", 32'(apple_valid), 32'd0);
        chk("full_apple_hold", 32'({apple_x, apple_y}), 32'({6'd0, 6'd1}));

        // Single free cell, four sweeps
        occ_mode = 3;
        randomseed = 12'h003;
        pulse_eat();
        wait_evt(12000, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("one_evt", 32'({saw_done, saw_fail}), 32'b10);
        chk("one_lat", 32'(n_cyc), 32'd10508);
        chk("one_apple", 32'({apple_x, apple_y}), 32'({6'd10, 6'd20}));
        chk("one_valid", 32'(apple_valid), 32'd1);

        // Eat during SCAN -> pending second spawn
        occ_mode = 0;
        randomseed = 12'h0FF;
        pulse_eat();
        repeat (5) @(negedge OSC_50);
        pulse_eat();
        wait_evt(400, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("pend_first", 32'(saw_done), 32'd1);
        chk("pend_first_apple", 32'({apple_x, apple_y}), 32'({6'd63, 6'd3}));
        randomseed = 12'h105;
        wait_evt(50, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("pend_second", 32'(saw_done), 32'd1);
        chk("pend_second_lat", 32'(n_cyc), 32'd8);
        chk("pend_second_apple", 32'({apple_x, apple_y}), 32'({6'd5, 6'd0}));

        // Abort mid-scan
        randomseed = 12'h0FF;
        pulse_eat();
        repeat (5) @(negedge OSC_50);
        pulse_eat();
        cstate = 2'b10;
        @(negedge OSC_50);
        chk("abort_busy", 32'(busy), 32'd0);
        wait_evt(300, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("abort_no_pulse", 32'({saw_done, saw_fail}), 32'd0);
        chk("abort_apple", 32'({apple_x, apple_y, apple_valid}), 32'({6'd5, 6'd0, 1'b1}));
        cstate = 2'b01;
        wait_evt(10, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("abort_pend_clr", 32'({saw_done, busy_cyc[0]}), 32'd0);

        // Eat while not playing is ignored
        cstate = 2'b00;
        pulse_eat();
        cstate = 2'b01;
        wait_evt(10, n_cyc, busy_cyc, saw_done, saw_fail);
        chk("noplay_ignored", 32'({saw_done, saw_fail, busy}), 32'd0);

        // Reset mid-scan
        pulse_eat();
        repeat (5) @(negedge OSC_50);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge OSC_50);
        chk("midrst_apple", 32'({apple_x, apple_y}), 32'({6'd1, 6'd1}));
        chk("midrst_state", 32'({apple_valid, busy, spawn_done, spawn_fail}), 32'b1000);
        chk("midrst_cand", 32'({cand_x, cand_y}), 32'd0);
        rst = 1'b0;
        @(negedge OSC_50);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
